counter_sequencer: RTL

COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

---
 rtl/counter_sequencer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/counter_sequencer.sv
// rtl/counter_sequencer.sv - run/pause/done sequencer driving an external decade counter
// Optional feature macro: CTRL_PRESCALER_EN (internal tick every DIV clocks while in RUN).
module counter_sequencer #(
  parameter int DIV = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic       tick,
  input  logic [3:0] target,
  input  logic       auto_reload,
  input  logic [3:0] count_in,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       busy,
  output logic       done,
  output logic [1:0] state,
  output logic [7:0] runs
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_PAUSED = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0] state_q, state_d;
  logic       cnt_en_q, cnt_en_d;
  logic       cnt_clr_q, cnt_clr_d;
  logic       done_q, done_d;
  logic [7:0] runs_q, runs_d;
  logic [3:0] limit;
  logic       terminal;
  logic       tick_int;

`ifdef CTRL_PRESCALER_EN
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic          unused_tick;

  assign unused_tick = tick;
  assign tick_int    = (state_q == S_RUN) && (presc_q == PW'(DIV - 1));

  // Prescaler: restarts on every entry to RUN, free-runs in RUN, holds elsewhere
  always_comb begin
    presc_d = presc_q;
    if ((state_d == S_RUN) && (state_q != S_RUN)) begin
      presc_d = '0;
    end else if (state_q == S_RUN) begin
      presc_d = tick_int ? '0 : presc_q + PW'(1);
    end
  end

  // Prescaler register
  always_ff @(posedge clk) begin
    if (!rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end
`else
  logic unused_div;

  assign unused_div = (DIV > 1);
  assign tick_int   = tick;
`endif

  // Targets above the decade range saturate at 9
  assign limit    = (target > 4'd9) ? 4'd9 : target;
  assign terminal = (count_in == limit);

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: clear > pause > start > tick
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: if (start) state_d = S_RUN;
        S_RUN: begin
          if (pause) begin
            state_d = S_PAUSED;
          end else if (tick_int && terminal) begin
            state_d = auto_reload ? S_RUN : S_DONE;
          end
        end
        S_PAUSED: if (start) state_d = S_RUN;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Output logic: one-cycle strobes and run counter, same priority as the state logic
  always_comb begin
    cnt_en_d  = 1'b0;
    cnt_clr_d = 1'b0;
    done_d    = 1'b0;
    runs_d    = runs_q;
    if (clear) begin
      cnt_clr_d = 1'b1;
      runs_d    = 8'd0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: if (start) cnt_clr_d = 1'b1;
        S_RUN: begin
          if (!pause && tick_int) begin
            if (terminal) begin
              cnt_clr_d = 1'b1;
              done_d    = 1'b1;
              runs_d    = (runs_q == 8'hFF) ? 8'hFF : runs_q + 8'd1;
            end else begin
              cnt_en_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Output registers; reset leaves a clear pending for the counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_en_q  <= 1'b0;
      cnt_clr_q <= 1'b1;
      done_q    <= 1'b0;
      runs_q    <= 8'd0;
    end else begin
      cnt_en_q  <= cnt_en_d;
      cnt_clr_q <= cnt_clr_d;
      done_q    <= done_d;
      runs_q    <= runs_d;
    end
  end

  assign cnt_en  = cnt_en_q;
  assign cnt_clr = cnt_clr_q;
  assign done    = done_q;
  assign runs    = runs_q;
  assign state   = state_q;
  assign busy    = (state_q == S_RUN) || (state_q == S_PAUSED);

endmodule
